// File: rtl/instr_encoder.sv
// Packs opcode/rs/rt/rd/imm into 32-bit words, buffers them and streams them to imem.
// Optional ENC_ERR_EN adds err_conflict: flags I-type sets whose rd disagrees with imm[15:11].
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int MEM_WORDS  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic              rewind,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              mem_full,
    output logic [ADDR_W:0]   words_written
`ifdef ENC_ERR_EN
    ,
    output logic              err_conflict
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE_C      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MEM_WORDS_C = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next, remain;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W:0]   words_reg, words_next;
    logic [31:0]       data_reg, data_next;
    logic              valid_reg, full_reg;
    logic [31:0]       in_word;
    logic              fire_in, fire_out;

    assign in_ready      = (count_reg != DEPTH_C) && !full_reg;
    assign fire_in       = in_valid && in_ready;
    assign fire_out      = valid_reg && wr_ready;
    assign wr_valid      = valid_reg;
    assign wr_addr       = addr_reg;
    assign wr_data       = data_reg;
    assign mem_full      = full_reg;
    assign words_written = words_reg;

    always_comb begin
        in_word = {opcode, rs, rt, imm};
        if (opcode == 6'h00)
            in_word = {opcode, rs, rt, rd, imm[10:0]};
    end

    always_comb begin
        count_next  = count_reg + CNT_W'(fire_in) - CNT_W'(fire_out);
        rd_ptr_next = rd_ptr_reg + PTR_W'(fire_out);
        wr_ptr_next = wr_ptr_reg + PTR_W'(fire_in);
        remain      = count_reg - CNT_W'(fire_out);

        // Output word register tracks the post-edge FIFO head; an empty FIFO bypasses the incoming word.
        data_next = data_reg;
        if (count_next != '0)
            data_next = (remain == '0) ? in_word : mem[rd_ptr_next];

        addr_next  = addr_reg;
        words_next = words_reg;
        if (rewind) begin
            addr_next  = BASE_C;
            words_next = '0;
        end else if (fire_out) begin
            addr_next  = addr_reg + ADDR_W'(1);
            words_next = words_reg + (ADDR_W + 1)'(1);
        end

        state_next = state_reg;
        if (rewind) begin
            state_next = (count_next != '0) ? WRITE : IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (count_next != '0) state_next = WRITE;
                WRITE: begin
                    if (fire_out && words_next == MEM_WORDS_C)
                        state_next = FULL;
                    else if (count_next == '0)
                        state_next = IDLE;
                end
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            addr_reg   <= BASE_C;
            words_reg  <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            full_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
            words_reg  <= words_next;
            data_reg   <= data_next;
            valid_reg  <= (state_next == WRITE);
            full_reg   <= (state_next == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (fire_in)
            mem[wr_ptr_reg] <= in_word;
    end

`ifdef ENC_ERR_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else
            err_reg <= fire_in && (opcode != 6'h00) && (rd != imm[15:11]);
    end

    assign err_conflict = err_reg;
`endif

endmodule
